keypad_scanner: RTL

- Initiator side of the 4x4 keypad interface.
- Drives the keypad rows one at a time and samples the columns, producing the one-hot row/col pair consumed by keypad_decoder.
- Synchronizes and debounces presses, emits one key_valid pulse per press, and holds scanning while a key is down.
- Sits between the keypad pins and keypad_decoder in the Lab 3 top level.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam logic [COLS-1:0] NO_KEY = 4'b0000;

    function automatic logic is_onehot(input logic [COLS-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; reset value set per instance.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad front end: drives one row at a time, debounces a
// single-column hit, and reports it as a one-hot row/col pair with a press pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    output logic [ROWS-1:0] row_onehot,
    output logic [COLS-1:0] col_onehot,
    output logic            key_valid,
    output logic            key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [COLS-1:0] col_sync;
    logic [COLS-1:0] col_act;

    scan_state_t     state_d, state_q;
    logic [DIV_W-1:0] dwell_d, dwell_q;
    logic [DB_W-1:0]  db_d, db_q;
    logic [1:0]       idx_d, idx_q;
    logic [ROWS-1:0]  cand_row_d, cand_row_q;
    logic [COLS-1:0]  cand_col_d, cand_col_q;
    logic [ROWS-1:0]  row_onehot_d, row_onehot_q;
    logic [COLS-1:0]  col_onehot_d, col_onehot_q;
    logic             key_valid_d, key_valid_q;
    logic             key_held_d, key_held_q;
    logic             tick;
    logic             cap_active;

    sync_2ff #(
        .WIDTH     (COLS),
        .RESET_VAL ({COLS{1'b1}})
    ) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (col_n),
        .q       (col_sync)
    );

    assign col_act    = ~col_sync;
    assign tick       = (state_q == SCAN) && (dwell_q == DIV_LAST);
    assign cap_active = |(col_act & cand_col_q);

    always_comb begin
        state_d      = state_q;
        dwell_d      = '0;
        db_d         = db_q;
        idx_d        = idx_q;
        cand_row_d   = cand_row_q;
        cand_col_d   = cand_col_q;
        row_onehot_d = row_onehot_q;
        col_onehot_d = col_onehot_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;

        case (state_q)
            SCAN: begin
                dwell_d = tick ? '0 : dwell_q + DIV_W'(1);
                if (tick) begin
                    // Row stays driven on a clean single-column hit so debounce sees the same key.
                    if (is_onehot(col_act)) begin
                        cand_row_d = ROWS'(1) << idx_q;
                        cand_col_d = col_act;
                        db_d       = '0;
                        state_d    = DEBOUNCE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (col_act == cand_col_q) begin
                    if (db_q == DB_LAST) begin
                        row_onehot_d = cand_row_q;
                        col_onehot_d = cand_col_q;
                        key_valid_d  = 1'b1;
                        key_held_d   = 1'b1;
                        state_d      = HELD;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end else begin
                    db_d    = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = SCAN;
                end
            end
            HELD: begin
                if (!cap_active) begin
                    db_d    = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (cap_active) begin
                    state_d = HELD;
                end else if (db_q == DB_LAST) begin
                    key_held_d = 1'b0;
                    idx_d      = idx_q + 2'd1;
                    state_d    = SCAN;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SCAN;
            dwell_q      <= '0;
            db_q         <= '0;
            idx_q        <= '0;
            cand_row_q   <= NO_KEY;
            cand_col_q   <= NO_KEY;
            row_onehot_q <= NO_KEY;
            col_onehot_q <= NO_KEY;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            db_q         <= db_d;
            idx_q        <= idx_d;
            cand_row_q   <= cand_row_d;
            cand_col_q   <= cand_col_d;
            row_onehot_q <= row_onehot_d;
            col_onehot_q <= col_onehot_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign row_n      = ~(ROWS'(1) << idx_q);
    assign row_onehot = row_onehot_q;
    assign col_onehot = col_onehot_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;

endmodule
